// File: rtl/regwrite_trace_buffer.sv
// Register-write trace buffer: timestamps every nonzero-rd regfile write into a FIFO drained by valid/ready.
// Optional feature macro TRACE_FILTER_EN adds a per-register trace_mask input.
module regwrite_trace_buffer #(
    parameter int DEPTH        = 16,
    parameter int CYCLE_W      = 16,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   stop,
    input  logic                   ctrl_writeEnable,
    input  logic [4:0]             ctrl_writeReg,
    input  logic [31:0]            data_writeReg,
`ifdef TRACE_FILTER_EN
    input  logic [31:0]            trace_mask,
`endif
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [CYCLE_W-1:0]     out_cycle,
    output logic [4:0]             out_reg,
    output logic [31:0]            out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [7:0]             drop_count,
    output logic [1:0]             state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             cur_state;
    state_t             next_state;
    logic [CYCLE_W-1:0] cycle_cnt;
    logic [CYCLE_W-1:0] mem_cycle [DEPTH];
    logic [4:0]         mem_reg   [DEPTH];
    logic [31:0]        mem_data  [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               reg_selected;
    logic               capture;
    logic               full;
    logic               do_push;
    logic               do_pop;
    logic               drop;

`ifdef TRACE_FILTER_EN
    assign reg_selected = trace_mask[ctrl_writeReg];
`else
    assign reg_selected = 1'b1;
`endif

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign capture   = (cur_state == CAPTURE) && ctrl_writeEnable && (ctrl_writeReg != 5'd0) && reg_selected;
    assign out_valid = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = out_valid && out_ready;
    assign do_push   = capture && (!full || do_pop);
    assign drop      = capture && full && !do_pop;

    assign out_cycle = mem_cycle[rd_ptr];
    assign out_reg   = mem_reg[rd_ptr];
    assign out_data  = mem_data[rd_ptr];
    assign state     = cur_state;

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE:    if (arm) next_state = CAPTURE;
            CAPTURE: if (stop || (drop && (STOP_ON_FULL != 0))) next_state = DONE;
            DONE:    if (arm) next_state = CAPTURE;
            default: next_state = IDLE;
        endcase
    end

    // Storage is cleared on reset so the head outputs read as zero afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state  <= IDLE;
            cycle_cnt  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_cycle[i] <= '0;
                mem_reg[i]   <= '0;
                mem_data[i]  <= '0;
            end
        end else begin
            cur_state <= next_state;
            cycle_cnt <= cycle_cnt + CYCLE_W'(1);
            if (do_push) begin
                mem_cycle[wr_ptr] <= cycle_cnt;
                mem_reg[wr_ptr]   <= ctrl_writeReg;
                mem_data[wr_ptr]  <= data_writeReg;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_regwrite_trace_buffer.sv
// Bench for regwrite_trace_buffer: two instances (drop-and-continue, stop-on-full with narrow timestamp)
// checked every cycle against a queue-based model, plus hand-computed expectations.
module tb_regwrite_trace_buffer;
    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        arm;
    logic        stop;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        out_ready;
`ifdef TRACE_FILTER_EN
    logic [31:0] trace_mask;
`endif

    logic        v0, v1;
    logic [15:0] cyc0;
    logic [3:0]  cyc1;
    logic [4:0]  reg0, reg1;
    logic [31:0] dat0, dat1;
    logic [4:0]  cnt0, cnt1;
    logic        ovf0, ovf1;
    logic [7:0]  drp0, drp1;
    logic [1:0]  st0, st1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    regwrite_trace_buffer #(.DEPTH(DEPTH), .CYCLE_W(16), .STOP_ON_FULL(0)) dut0 (
        .clock(clock), .reset(reset), .arm(arm), .stop(stop),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
`ifdef TRACE_FILTER_EN
        .trace_mask(trace_mask),
`endif
        .out_ready(out_ready), .out_valid(v0), .out_cycle(cyc0), .out_reg(reg0), .out_data(dat0),
        .count(cnt0), .overflow(ovf0), .drop_count(drp0), .state(st0)
    );

    regwrite_trace_buffer #(.DEPTH(DEPTH), .CYCLE_W(4), .STOP_ON_FULL(1)) dut1 (
        .clock(clock), .reset(reset), .arm(arm), .stop(stop),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
`ifdef TRACE_FILTER_EN
        .trace_mask(trace_mask),
`endif
        .out_ready(out_ready), .out_valid(v1), .out_cycle(cyc1), .out_reg(reg1), .out_data(dat1),
        .count(cnt1), .overflow(ovf1), .drop_count(drp1), .state(st1)
    );

    // Model: one queue of trace entries per instance, updated from the inputs at each rising edge.
    typedef struct packed {
        logic [31:0] cyc;
        logic [4:0]  rg;
        logic [31:0] dat;
    } ent_t;

    ent_t        mq [2][$];
    int unsigned m_cycle [2];
    int          m_state [2];
    bit          m_ovf   [2];
    int          m_drops [2];
    int unsigned cyc_mod [2] = '{32'd65536, 32'd16};
    int          stop_full [2] = '{0, 1};
    bit          model_live = 1'b0;
    bit          m_want;
    bit          m_dropped;
    bit          m_mask_ok;

    always @(posedge clock) begin
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                mq[m].delete();
                m_state[m] = 0;
                m_cycle[m] = 0;
                m_ovf[m]   = 1'b0;
                m_drops[m] = 0;
                model_live = 1'b1;
            end else begin
`ifdef TRACE_FILTER_EN
                m_mask_ok = trace_mask[ctrl_writeReg];
`else
                m_mask_ok = 1'b1;
`endif
                m_want = (m_state[m] == 1) && ctrl_writeEnable && (ctrl_writeReg != 0) && m_mask_ok;
                if (mq[m].size() > 0 && out_ready) begin
                    void'(mq[m].pop_front());
                end
                m_dropped = 1'b0;
                if (m_want) begin
                    if (mq[m].size() < DEPTH) begin
                        mq[m].push_back({m_cycle[m], ctrl_writeReg, data_writeReg});
                    end else begin
                        m_dropped = 1'b1;
                        m_ovf[m]  = 1'b1;
                        if (m_drops[m] < 255) m_drops[m]++;
                    end
                end
                if (m_state[m] == 1) begin
                    if (stop || (m_dropped && stop_full[m] != 0)) m_state[m] = 2;
                end else if (arm) begin
                    m_state[m] = 1;
                end
                m_cycle[m] = (m_cycle[m] + 1) % cyc_mod[m];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compare_dut(input int m, input logic v, input logic [31:0] cyc, input logic [4:0] rg,
                               input logic [31:0] dat, input logic [4:0] cnt, input logic ovf,
                               input logic [7:0] drp, input logic [1:0] st);
        checkOutput($sformatf("dut%0d.out_valid", m), 64'(v), 64'(mq[m].size() != 0));
        checkOutput($sformatf("dut%0d.count", m), 64'(cnt), 64'(mq[m].size()));
        checkOutput($sformatf("dut%0d.overflow", m), 64'(ovf), 64'(m_ovf[m]));
        checkOutput($sformatf("dut%0d.drop_count", m), 64'(drp), 64'(m_drops[m]));
        checkOutput($sformatf("dut%0d.state", m), 64'(st), 64'(m_state[m]));
        if (mq[m].size() != 0) begin
            checkOutput($sformatf("dut%0d.out_cycle", m), 64'(cyc), 64'(mq[m][0].cyc));
            checkOutput($sformatf("dut%0d.out_reg", m), 64'(rg), 64'(mq[m][0].rg));
            checkOutput($sformatf("dut%0d.out_data", m), 64'(dat), 64'(mq[m][0].dat));
        end
    endtask

    always @(negedge clock) begin
        if (model_live) begin
            compare_dut(0, v0, 32'(cyc0), reg0, dat0, cnt0, ovf0, drp0, st0);
            compare_dut(1, v1, 32'(cyc1), reg1, dat1, cnt1, ovf1, drp1, st1);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic a, input logic s, input logic we, input logic [4:0] rg,
                                 input logic [31:0] dat, input logic rdy);
        arm              = a;
        stop             = s;
        ctrl_writeEnable = we;
        ctrl_writeReg    = rg;
        data_writeReg    = dat;
        out_ready        = rdy;
        tick();
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; stop = 1'b0; ctrl_writeEnable = 1'b0;
        ctrl_writeReg = '0; data_writeReg = '0; out_ready = 1'b0;
`ifdef TRACE_FILTER_EN
        trace_mask = '1;
`endif
        tick();
        reset = 1'b0;
        checkOutput("reset_state", 64'(st0), 64'd0);
        checkOutput("reset_count", 64'(cnt0), 64'd0);
        checkOutput("reset_valid", 64'(v0), 64'd0);
        checkOutput("reset_out_cycle", 64'(cyc0), 64'd0);
        checkOutput("reset_out_reg", 64'(reg0), 64'd0);
        checkOutput("reset_out_data", 64'(dat0), 64'd0);
        checkOutput("reset_overflow", 64'(ovf0), 64'd0);
        checkOutput("reset_drops", 64'(drp0), 64'd0);

        // Cycles 0..5: write before arm, arm at 2, captured write at 4, r0 write at 5
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 0);
        applyStimulus(0, 0, 1, 5'd3, 32'd1, 0);
        checkOutput("prearm_ignored", 64'(cnt0), 64'd0);
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 0);
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 0);
        applyStimulus(0, 0, 1, 5'd5, 32'hDEADBEEF, 0);
        checkOutput("first_valid", 64'(v0), 64'd1);
        checkOutput("first_cycle", 64'(cyc0), 64'd4);
        checkOutput("first_reg", 64'(reg0), 64'd5);
        checkOutput("first_data", 64'(dat0), 64'hDEADBEEF);
        checkOutput("first_count", 64'(cnt0), 64'd1);
        applyStimulus(0, 0, 1, 5'd0, 32'd7, 0);
        checkOutput("r0_ignored", 64'(cnt0), 64'd1);
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 1);
        checkOutput("drained_first", 64'(v0), 64'd0);

        // Write on the stop edge is captured; write after stop is not
        applyStimulus(0, 1, 1, 5'd7, 32'h11, 0);
        checkOutput("stop_state", 64'(st0), 64'd2);
        checkOutput("stop_write_count", 64'(cnt0), 64'd1);
        checkOutput("stop_write_reg", 64'(reg0), 64'd7);
        applyStimulus(0, 0, 1, 5'd3, 32'd2, 0);
        checkOutput("poststop_ignored", 64'(cnt0), 64'd1);
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 1);

        // Overflow: 18 writes into an empty 16-entry FIFO
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 0);
        for (int i = 0; i < 18; i++) applyStimulus(0, 0, 1, 5'd1, 32'(i), 0);
        checkOutput("ovf_count", 64'(cnt0), 64'd16);
        checkOutput("ovf_flag", 64'(ovf0), 64'd1);
        checkOutput("ovf_drops", 64'(drp0), 64'd2);
        checkOutput("sof_state", 64'(st1), 64'd2);
        checkOutput("sof_drops", 64'(drp1), 64'd1);
        checkOutput("sof_count", 64'(cnt1), 64'd16);
        for (int i = 0; i < 16; i++) begin
            checkOutput("drain_order", 64'(dat0), 64'(i));
            applyStimulus(0, 0, 0, 5'd0, 32'd0, 1);
        end
        checkOutput("drain_empty0", 64'(v0), 64'd0);
        checkOutput("drain_empty1", 64'(v1), 64'd0);

        // Re-arm keeps overflow; full FIFO push+pop is accepted
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 0);
        checkOutput("rearm_state", 64'(st1), 64'd1);
        checkOutput("rearm_overflow", 64'(ovf1), 64'd1);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 5'd2, 32'(100 + i), 0);
        applyStimulus(0, 0, 1, 5'd2, 32'hAA, 1);
        checkOutput("fullpp_count0", 64'(cnt0), 64'd16);
        checkOutput("fullpp_drops0", 64'(drp0), 64'd2);
        checkOutput("fullpp_count1", 64'(cnt1), 64'd16);
        checkOutput("fullpp_drops1", 64'(drp1), 64'd1);
        checkOutput("fullpp_head", 64'(dat0), 64'd101);
        applyStimulus(0, 1, 0, 5'd0, 32'd0, 0);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, 5'd0, 32'd0, 1);
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 0);
        applyStimulus(0, 0, 1, 5'd4, 32'h44, 1);
        checkOutput("empty_pushpop_count", 64'(cnt0), 64'd1);

        // Reset mid-capture with 9 entries buffered
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 5'd6, 32'(200 + i), 0);
        checkOutput("pre_reset_count", 64'(cnt0), 64'd9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midreset_count", 64'(cnt0), 64'd0);
        checkOutput("midreset_valid", 64'(v0), 64'd0);
        checkOutput("midreset_overflow", 64'(ovf0), 64'd0);
        checkOutput("midreset_state", 64'(st0), 64'd0);
        checkOutput("midreset_out_data", 64'(dat0), 64'd0);
        applyStimulus(1, 0, 0, 5'd0, 32'd0, 0);
        applyStimulus(0, 0, 1, 5'd9, 32'h99, 0);
        checkOutput("restart_cycle0", 64'(cyc0), 64'd1);
        checkOutput("restart_cycle1", 64'(cyc1), 64'd1);

`ifdef TRACE_FILTER_EN
        trace_mask = 32'h4;
        applyStimulus(0, 0, 1, 5'd2, 32'h22, 0);
        applyStimulus(0, 0, 1, 5'd3, 32'h33, 0);
        checkOutput("filter_count", 64'(cnt0), 64'd2);
        checkOutput("filter_drops", 64'(drp0), 64'd0);
        trace_mask = '1;
`endif

        applyStimulus(0, 0, 0, 5'd0, 32'd0, 1);
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 1);
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
